vga_frame_ctl: RTL and testbench
================================

// Module: vga_frame_ctl
// PURPOSE
//  Sequencer for the 1024x768@60 (65 MHz) VGA pixel pipeline.
//  Generates hcount/vcount, sync and blanking from the timing constants.
//  Owns the frame-synchronous object position (pos_x/pos_y) used by the draw stages.
//  Position updates from game logic are taken through a req/ack handshake and applied
//  only at vertical-blank start, so no frame is ever drawn with a torn position.
// PARAMETERS
//  H_TOT        1344  horizontal period in pixels; hcount wraps at H_TOT-1
//  H_BLNK_START 1024  first horizontal blanking pixel
//  H_SYNC_START 1048  first hsync pixel
//  H_SYNC_END   1184  first pixel after hsync
//  V_TOT        806   vertical period in lines; vcount wraps at V_TOT-1
//  V_BLNK_START 768   first vertical blanking line
//  V_SYNC_START 771   first vsync line
//  V_SYNC_END   777   first line after vsync
//  X_INIT       600   pos_x reset value
//  Y_INIT       100   pos_y reset value
// PORTS
//  clk         in   1   pixel clock, 65 MHz
//  rst         in   1   asynchronous, active-high reset
//  en          in   1   count enable; low freezes the timing counters and all timing outputs
//  cfg_req     in   1   position update request; hold until cfg_ack
//  cfg_x       in   11  requested x; must be stable while cfg_req is high
//  cfg_y       in   11  requested y; must be stable while cfg_req is high
//  cfg_ack     out  1   one-cycle pulse: request applied to pos_x/pos_y
//  hcount      out  11  pixel counter, 0..H_TOT-1
//  vcount      out  11  line counter, 0..V_TOT-1
//  hsync       out  1   active high; invert at the top level if the monitor needs it
//  vsync       out  1   active high
//  hblnk       out  1   high for hcount >= H_BLNK_START
//  vblnk       out  1   high for vcount >= V_BLNK_START
//  frame_start out  1   one-cycle pulse while hcount==0 && vcount==0
//  pos_x       out  11  frame-stable x for the draw stages
//  pos_y       out  11  frame-stable y for the draw stages
// BEHAVIOUR
//  Reset values: hcount=vcount=0, hsync=vsync=hblnk=vblnk=0, frame_start=0, cfg_ack=0,
//   pos_x=X_INIT, pos_y=Y_INIT, FSM=IDLE, shadow registers=0.
//  Counting: on each en=1 clock, hcount++. At H_TOT-1, hcount->0 and vcount++.
//   At (H_TOT-1, V_TOT-1), both counters go to 0.
//  All outputs are registered and decoded from next-state counts, so every output is
//   aligned with the hcount/vcount value of the same cycle (zero relative latency).
//  Decode: hsync = H_SYNC_START<=hcount<H_SYNC_END; vsync = V_SYNC_START<=vcount<V_SYNC_END.
//  en=0: counters and timing outputs hold their values; frame_start is forced to 0.
//  vb_edge: an en=1 clock whose next counts are (0, V_BLNK_START).
//  FSM, state IDLE:    cfg_req=1 -> capture shadow values, go to PENDING.
//   Capture clamps: x = min(cfg_x, 1023), y = min(cfg_y, 767).
//  FSM, state PENDING: on vb_edge -> pos <= shadow, cfg_ack <= 1, go to ACK.
//   cfg_req is ignored in PENDING.
//  FSM, state ACK:     cfg_ack <= 0, go to IDLE. cfg_req is ignored in ACK.
//   The requester drops cfg_req in the cycle it samples cfg_ack=1.
//  A request captured in the same cycle as vb_edge is applied at the next frame's vb_edge.
//  pos_x/pos_y change only on vb_edge, so they are constant for the whole active area.
//  rst mid-PENDING: request discarded, no cfg_ack issued, pos returns to X_INIT/Y_INIT.
// TESTING
//  T1 reset, en=1, run 1344*806 clocks:
//   hblnk rises at h=1024; hsync high exactly for h=1048..1183; vsync high for v=771..776;
//   frame_start pulses once, at (0,0), with period exactly 1083264 clocks.
//  T2 wrap: at h=1343 v=805, next cycle is (0,0) with frame_start=1 and vblnk=0.
//   At h=1343 v=767, next cycle is (0,768) with vblnk=1.
//  T3 cfg_req with x=300 y=200 at v=100:
//   pos stays 600/100 until (0,768); pos becomes 300/200 in that cycle;
//   cfg_ack is high for exactly 1 cycle.
//  T4 cfg_x=2000, cfg_y=900 -> applied pos_x=1023, pos_y=767.
//   A second request held during PENDING/ACK is not captured until after IDLE is re-entered.
//  T5 en toggled 0 for 50 clocks mid-line: counts and syncs hold their values;
//   the frame period grows by exactly 50 clocks; no extra frame_start pulse.
//  T6 rst asserted while PENDING: all outputs reach reset values immediately (async);
//   no cfg_ack follows; pos=600/100.

Source files
------------

// File: rtl/vga_frame_ctl.sv
// ---------------------------------------------------------------------------
// vga_frame_ctl
//   Timing sequencer for the 1024x768@60 (65 MHz) VGA pixel pipeline.
//   Generates hcount/vcount, sync and blanking, and owns the frame-stable
//   object position (pos_x/pos_y) used by the draw stages.
//
//   Position update handshake (req/ack):
//     The requester raises cfg_req with cfg_x/cfg_y stable and holds all
//     three until it samples cfg_ack=1, then drops cfg_req in that cycle.
//     The request is captured (clamped) into shadow registers while IDLE.
//     It is applied to pos_x/pos_y on the clock that enters vertical blanking,
//     and cfg_ack pulses high for exactly that one cycle. cfg_req is ignored
//     while a capture is pending or being acknowledged.
//
// Ports
//   clk, rst          pixel clock, asynchronous active-high reset
//   en                count enable; low freezes counters and timing outputs
//   cfg_req/x/y       position update request and requested coordinates
//   cfg_ack           one-cycle pulse: request applied to pos_x/pos_y
//   hcount, vcount    pixel / line counters
//   hsync, vsync      active-high sync pulses
//   hblnk, vblnk      blanking flags
//   frame_start       one-cycle pulse at (0,0)
//   pos_x, pos_y      frame-stable position for the draw stages
//   state_dbg         current handshake FSM state (0 IDLE, 1 PENDING, 2 ACK)
// ---------------------------------------------------------------------------
module vga_frame_ctl #(
  parameter int H_TOT        = 1344,
  parameter int H_BLNK_START = 1024,
  parameter int H_SYNC_START = 1048,
  parameter int H_SYNC_END   = 1184,
  parameter int V_TOT        = 806,
  parameter int V_BLNK_START = 768,
  parameter int V_SYNC_START = 771,
  parameter int V_SYNC_END   = 777,
  parameter int X_INIT       = 600,
  parameter int Y_INIT       = 100,
  parameter int X_MAX        = 1023,
  parameter int Y_MAX        = 767
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        cfg_req,
  input  logic [10:0] cfg_x,
  input  logic [10:0] cfg_y,
  output logic        cfg_ack,
  output logic [10:0] hcount,
  output logic [10:0] vcount,
  output logic        hsync,
  output logic        vsync,
  output logic        hblnk,
  output logic        vblnk,
  output logic        frame_start,
  output logic [10:0] pos_x,
  output logic [10:0] pos_y,
  output logic [1:0]  state_dbg
);

  localparam logic [10:0] H_LAST = 11'(H_TOT - 1);
  localparam logic [10:0] V_LAST = 11'(V_TOT - 1);
  localparam logic [10:0] H_BS   = 11'(H_BLNK_START);
  localparam logic [10:0] H_SS   = 11'(H_SYNC_START);
  localparam logic [10:0] H_SE   = 11'(H_SYNC_END);
  localparam logic [10:0] V_BS   = 11'(V_BLNK_START);
  localparam logic [10:0] V_SS   = 11'(V_SYNC_START);
  localparam logic [10:0] V_SE   = 11'(V_SYNC_END);
  localparam logic [10:0] X_RST  = 11'(X_INIT);
  localparam logic [10:0] Y_RST  = 11'(Y_INIT);
  localparam logic [10:0] X_CLMP = 11'(X_MAX);
  localparam logic [10:0] Y_CLMP = 11'(Y_MAX);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    ACK     = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [10:0] h_nxt, v_nxt;
  logic        vb_edge;
  logic [10:0] shadow_x, shadow_y, shadow_x_nxt, shadow_y_nxt;
  logic [10:0] pos_x_nxt, pos_y_nxt;
  logic        ack_nxt;

  // Next counts. Every timing output is decoded from these and registered
  // together with the counters, so outputs line up with the counts they
  // describe in the same cycle.
  always_comb begin
    h_nxt = hcount + 11'd1;
    v_nxt = vcount;
    if (hcount == H_LAST) begin
      h_nxt = 11'd0;
      v_nxt = (vcount == V_LAST) ? 11'd0 : vcount + 11'd1;
    end
  end

  // Clock that lands on the first pixel of the first blanking line.
  assign vb_edge = en && (h_nxt == 11'd0) && (v_nxt == V_BS);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hcount      <= 11'd0;
      vcount      <= 11'd0;
      hsync       <= 1'b0;
      vsync       <= 1'b0;
      hblnk       <= 1'b0;
      vblnk       <= 1'b0;
      frame_start <= 1'b0;
    end else if (en) begin
      hcount      <= h_nxt;
      vcount      <= v_nxt;
      hsync       <= (h_nxt >= H_SS) && (h_nxt < H_SE);
      vsync       <= (v_nxt >= V_SS) && (v_nxt < V_SE);
      hblnk       <= (h_nxt >= H_BS);
      vblnk       <= (v_nxt >= V_BS);
      frame_start <= (h_nxt == 11'd0) && (v_nxt == 11'd0);
    end else begin
      frame_start <= 1'b0;
    end
  end

  // Handshake FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      shadow_x <= 11'd0;
      shadow_y <= 11'd0;
      pos_x    <= X_RST;
      pos_y    <= Y_RST;
      cfg_ack  <= 1'b0;
    end else begin
      state    <= state_nxt;
      shadow_x <= shadow_x_nxt;
      shadow_y <= shadow_y_nxt;
      pos_x    <= pos_x_nxt;
      pos_y    <= pos_y_nxt;
      cfg_ack  <= ack_nxt;
    end
  end

  // Handshake FSM: next state and datapath. A request captured on the same
  // clock as vb_edge waits for the following frame's vb_edge, because the
  // apply step only happens from PENDING.
  always_comb begin
    state_nxt    = state;
    shadow_x_nxt = shadow_x;
    shadow_y_nxt = shadow_y;
    pos_x_nxt    = pos_x;
    pos_y_nxt    = pos_y;
    ack_nxt      = 1'b0;
    case (state)
      IDLE: begin
        if (cfg_req) begin
          shadow_x_nxt = (cfg_x > X_CLMP) ? X_CLMP : cfg_x;
          shadow_y_nxt = (cfg_y > Y_CLMP) ? Y_CLMP : cfg_y;
          state_nxt    = PENDING;
        end
      end
      PENDING: begin
        if (vb_edge) begin
          pos_x_nxt = shadow_x;
          pos_y_nxt = shadow_y;
          ack_nxt   = 1'b1;
          state_nxt = ACK;
        end
      end
      ACK: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_vga_frame_ctl.sv
// ---------------------------------------------------------------------------
// tb_vga_frame_ctl
//   Directed bench for vga_frame_ctl, built with a reduced timing set so that
//   whole frames fit in a short run:
//     H: total 48, blank 32, sync 36..39      V: total 16, blank 10, sync 11..12
//     frame = 48*16 = 768 clocks
//   Position reset values and clamp limits keep their real defaults.
// ---------------------------------------------------------------------------
module tb_vga_frame_ctl;

  localparam int HT = 48, HB = 32, HSS = 36, HSE = 40;
  localparam int VT = 16, VB = 10, VSS = 11, VSE = 13;
  localparam int FRAME = HT * VT;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        cfg_req;
  logic [10:0] cfg_x, cfg_y;
  logic        cfg_ack;
  logic [10:0] hcount, vcount;
  logic        hsync, vsync, hblnk, vblnk, frame_start;
  logic [10:0] pos_x, pos_y;
  logic [1:0]  state_dbg;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  vga_frame_ctl #(
    .H_TOT(HT), .H_BLNK_START(HB), .H_SYNC_START(HSS), .H_SYNC_END(HSE),
    .V_TOT(VT), .V_BLNK_START(VB), .V_SYNC_START(VSS), .V_SYNC_END(VSE)
  ) dut (
    .clk(clk), .rst(rst), .en(en),
    .cfg_req(cfg_req), .cfg_x(cfg_x), .cfg_y(cfg_y), .cfg_ack(cfg_ack),
    .hcount(hcount), .vcount(vcount),
    .hsync(hsync), .vsync(vsync), .hblnk(hblnk), .vblnk(vblnk),
    .frame_start(frame_start),
    .pos_x(pos_x), .pos_y(pos_y), .state_dbg(state_dbg)
  );

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
               tag, got, got, exp, exp, cyc);
    end
  endtask

  // Reference timing model: counts only on enabled clocks.
  int   m_h = 0, m_v = 0;
  logic m_fs = 1'b0;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_h = 0; m_v = 0; m_fs = 1'b0;
    end else if (en) begin
      if (m_h == HT - 1) begin
        m_h = 0;
        m_v = (m_v == VT - 1) ? 0 : m_v + 1;
      end else begin
        m_h = m_h + 1;
      end
      m_fs = (m_h == 0) && (m_v == 0);
    end else begin
      m_fs = 1'b0;
    end
  end

  // Per-cycle check of all timing outputs against the model, on the falling edge.
  logic mon_on = 1'b0;
  always @(negedge clk) begin
    if (mon_on) begin
      exp_q.push_back({5'd0, 11'(m_h), 11'(m_v),
                       (m_h >= HSS) && (m_h < HSE), (m_v >= VSS) && (m_v < VSE),
                       (m_h >= HB), (m_v >= VB), m_fs});
      chk("timing", {5'd0, hcount, vcount, hsync, vsync, hblnk, vblnk, frame_start},
          exp_q.pop_front());
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_hv(input int h, input int v);
    int i = 0;
    while (!(hcount == 11'(h) && vcount == 11'(v)) && i < 2 * FRAME) begin
      step(1);
      i++;
    end
    chk("wait_hv_timeout", {21'd0, hcount}, 32'(h));
  endtask

  task automatic wait_state(input logic [1:0] s);
    int i = 0;
    while (state_dbg != s && i < 8) begin
      step(1);
      i++;
    end
    chk("wait_state", {30'd0, state_dbg}, {30'd0, s});
  endtask

  task automatic wait_fs(output int t);
    int i = 0;
    step(1);
    while (!frame_start && i < 3 * FRAME) begin
      step(1);
      i++;
    end
    chk("wait_fs_timeout", {31'd0, frame_start}, 32'd1);
    t = cyc;
  endtask

  // Waits for cfg_ack; counts cycles where pos moved away from (hx,hy) first.
  task automatic wait_ack(input logic [10:0] hx, input logic [10:0] hy,
                          output bit ok, output int bad);
    ok = 0;
    bad = 0;
    for (int i = 0; i < 2 * FRAME + 10; i++) begin
      step(1);
      if (cfg_ack) begin
        ok = 1;
        break;
      end
      if (pos_x !== hx || pos_y !== hy) bad++;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  t0, t1, n_hs, n_vs, n_hb, n_vb, n_fs, bad, n_ack;
    bit  ok;

    rst = 1'b0; en = 1'b0; cfg_req = 1'b0; cfg_x = '0; cfg_y = '0;
    #1 rst = 1'b1;
    #2 mon_on = 1'b1;
    step(2);

    // Reset state
    chk("rst_hcount", {21'd0, hcount}, 32'd0);
    chk("rst_vcount", {21'd0, vcount}, 32'd0);
    chk("rst_flags", {27'd0, hsync, vsync, hblnk, vblnk, frame_start}, 32'd0);
    chk("rst_ack", {31'd0, cfg_ack}, 32'd0);
    chk("rst_pos_x", {21'd0, pos_x}, 32'd600);
    chk("rst_pos_y", {21'd0, pos_y}, 32'd100);
    chk("rst_state", {30'd0, state_dbg}, 32'd0);

    @(negedge clk);
    rst = 1'b0;
    en  = 1'b1;
    step(1);

    // T1: one full frame window, per-frame activity counts
    n_hs = 0; n_vs = 0; n_hb = 0; n_vb = 0; n_fs = 0;
    for (int i = 0; i < FRAME; i++) begin
      step(1);
      n_hs += int'(hsync); n_vs += int'(vsync);
      n_hb += int'(hblnk); n_vb += int'(vblnk); n_fs += int'(frame_start);
    end
    chk("t1_hsync_cycles", n_hs, 32'd64);
    chk("t1_vsync_cycles", n_vs, 32'd96);
    chk("t1_hblnk_cycles", n_hb, 32'd256);
    chk("t1_vblnk_cycles", n_vb, 32'd288);
    chk("t1_fs_pulses", n_fs, 32'd1);

    wait_hv(31, 4);
    chk("t1_hblnk_h31", {31'd0, hblnk}, 32'd0);
    step(1);
    chk("t1_hblnk_h32", {31'd0, hblnk}, 32'd1);
    wait_hv(35, 4);
    chk("t1_hsync_h35", {31'd0, hsync}, 32'd0);
    step(1);
    chk("t1_hsync_h36", {31'd0, hsync}, 32'd1);
    step(3);
    chk("t1_hsync_h39", {31'd0, hsync}, 32'd1);
    step(1);
    chk("t1_hsync_h40", {31'd0, hsync}, 32'd0);

    wait_fs(t0);
    wait_fs(t1);
    chk("t1_frame_period", t1 - t0, FRAME);

    // T2: wrap points
    wait_hv(HT - 1, VT - 1);
    step(1);
    chk("t2_wrap_hv", {10'd0, hcount, vcount}, 32'd0);
    chk("t2_wrap_fs", {31'd0, frame_start}, 32'd1);
    chk("t2_wrap_vblnk", {31'd0, vblnk}, 32'd0);
    wait_hv(HT - 1, VB - 1);
    chk("t2_pre_vblnk", {31'd0, vblnk}, 32'd0);
    step(1);
    chk("t2_vb_hv", {10'd0, hcount, vcount}, {21'd0, 11'(VB)});
    chk("t2_vb_vblnk", {31'd0, vblnk}, 32'd1);

    // T3: request mid-frame, applied at vertical blank start
    wait_hv(0, 3);
    cfg_x = 11'd300; cfg_y = 11'd200; cfg_req = 1'b1;
    wait_ack(11'd600, 11'd100, ok, bad);
    chk("t3_ack_seen", {31'd0, ok}, 32'd1);
    chk("t3_pos_held", bad, 32'd0);
    chk("t3_ack_hv", {10'd0, hcount, vcount}, {21'd0, 11'(VB)});
    chk("t3_pos_x", {21'd0, pos_x}, 32'd300);
    chk("t3_pos_y", {21'd0, pos_y}, 32'd200);
    cfg_req = 1'b0;
    n_ack = 0;
    for (int i = 0; i < 8; i++) begin
      step(1);
      n_ack += int'(cfg_ack);
    end
    chk("t3_ack_width", n_ack, 32'd0);
    chk("t3_state_idle", {30'd0, state_dbg}, 32'd0);

    // T4: clamping, and a second request held through PENDING/ACK
    wait_hv(0, 2);
    cfg_x = 11'd2000; cfg_y = 11'd900; cfg_req = 1'b1;
    wait_state(2'd1);
    cfg_req = 1'b0;
    step(1);
    cfg_x = 11'd5; cfg_y = 11'd6; cfg_req = 1'b1;
    wait_ack(11'd300, 11'd200, ok, bad);
    chk("t4_ack_seen", {31'd0, ok}, 32'd1);
    chk("t4_pos_held", bad, 32'd0);
    chk("t4_clamp_x", {21'd0, pos_x}, 32'd1023);
    chk("t4_clamp_y", {21'd0, pos_y}, 32'd767);
    chk("t4_state_ack", {30'd0, state_dbg}, 32'd2);
    step(1);
    chk("t4_state_idle", {30'd0, state_dbg}, 32'd0);
    step(1);
    chk("t4_state_recapture", {30'd0, state_dbg}, 32'd1);
    wait_ack(11'd1023, 11'd767, ok, bad);
    chk("t4_ack2_seen", {31'd0, ok}, 32'd1);
    chk("t4_pos2_held", bad, 32'd0);
    chk("t4_pos2", {10'd0, pos_x, pos_y}, {10'd0, 11'd5, 11'd6});
    cfg_req = 1'b0;
    step(1);

    // T5: en low for 50 clocks mid-line, inside both sync pulses
    wait_fs(t0);
    wait_hv(37, 11);
    en = 1'b0;
    n_fs = 0;
    for (int i = 0; i < 50; i++) begin
      step(1);
      n_fs += int'(frame_start);
    end
    chk("t5_hold_hv", {10'd0, hcount, vcount}, {10'd0, 11'd37, 11'd11});
    chk("t5_hold_sync", {30'd0, hsync, vsync}, 32'd3);
    chk("t5_no_fs", n_fs, 32'd0);
    en = 1'b1;
    wait_fs(t1);
    chk("t5_frame_period", t1 - t0, FRAME + 50);

    // T6: asynchronous reset while a request is pending
    wait_hv(0, 2);
    cfg_x = 11'd7; cfg_y = 11'd8; cfg_req = 1'b1;
    wait_state(2'd1);
    cfg_req = 1'b0;
    step(3);
    #2 rst = 1'b1;
    #1;
    chk("t6_async_hv", {10'd0, hcount, vcount}, 32'd0);
    chk("t6_async_flags", {26'd0, hsync, vsync, hblnk, vblnk, frame_start, cfg_ack}, 32'd0);
    chk("t6_async_pos", {10'd0, pos_x, pos_y}, {10'd0, 11'd600, 11'd100});
    chk("t6_async_state", {30'd0, state_dbg}, 32'd0);
    step(1);
    rst = 1'b0;
    n_ack = 0;
    bad = 0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      step(1);
      n_ack += int'(cfg_ack);
      if (pos_x !== 11'd600 || pos_y !== 11'd100) bad++;
    end
    chk("t6_no_ack", n_ack, 32'd0);
    chk("t6_pos_reset", bad, 32'd0);
    chk("t6_state_idle", {30'd0, state_dbg}, 32'd0);

    // ---------------- report ----------------
    mon_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
